// File: rtl/skid_fifo.sv
// skid_fifo: DEPTH-entry elastic buffer with registered ready_in/valid_out/data_out,
// optional drop-oldest overwrite, synchronous flush, occupancy and saturating drop counters.
module skid_fifo #(
   parameter int DATA_WIDTH     = 8,
   parameter int DEPTH          = 4,
   parameter bit OVERWRITE_MODE = 1'b0,
   parameter int DROP_CNT_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic [DATA_WIDTH-1:0]      data_in,
   input  logic                       valid_in,
   output logic                       ready_in,
   output logic [DATA_WIDTH-1:0]      data_out,
   output logic                       valid_out,
   input  logic                       ready_out,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic [DROP_CNT_WIDTH-1:0]  drop_count
);
   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = $clog2(DEPTH);
   if (DEPTH < 2) begin : g_depth_chk
      $error("skid_fifo: DEPTH must be >= 2");
   end
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]         r_rd, r_wr, w_rd_inc, w_wr_inc, w_rd_next;
   logic                  w_insert, w_remove, w_drop;
   logic [CW-1:0]         w_count_next;
   logic [DATA_WIDTH-1:0] w_head;
   always_comb begin
      w_insert     = valid_in & ready_in;
      w_remove     = valid_out & ready_out;
      w_drop       = OVERWRITE_MODE & (count == CW'(DEPTH)) & w_insert & ~w_remove & ~flush;
      w_rd_inc     = (r_rd == PW'(DEPTH-1)) ? '0 : r_rd + PW'(1);
      w_wr_inc     = (r_wr == PW'(DEPTH-1)) ? '0 : r_wr + PW'(1);
      w_rd_next    = (w_remove | w_drop) ? w_rd_inc : r_rd;
      w_count_next = flush ? '0 : count + CW'(w_insert) - CW'(w_remove | w_drop);
      // the new item becomes the head when it lands where the read pointer is heading
      w_head       = (w_insert && w_rd_next == r_wr) ? data_in : r_mem[w_rd_next];
   end
   always_ff @(posedge clk)
      if (w_insert && !flush) r_mem[r_wr] <= data_in;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_rd       <= '0;
         r_wr       <= '0;
         count      <= '0;
         ready_in   <= 1'b1;
         valid_out  <= 1'b0;
         data_out   <= '0;
         drop_count <= '0;
      end else begin
         r_rd      <= flush ? '0 : w_rd_next;
         r_wr      <= flush ? '0 : (w_insert ? w_wr_inc : r_wr);
         count     <= w_count_next;
         ready_in  <= (w_count_next < CW'(DEPTH)) | OVERWRITE_MODE;
         valid_out <= w_count_next != '0;
         data_out  <= w_head;
         if (w_drop && drop_count != '1) drop_count <= drop_count + DROP_CNT_WIDTH'(1);
      end
endmodule

// File: tb/tb_skid_fifo.sv
// tb_skid_fifo: four skid_fifo variants (DEPTH 4/3 x overwrite off/on) on shared stimulus,
// directed checks plus a queue scoreboard checking every instance every cycle.
module tb_skid_fifo;
   logic       clk = 1'b0;
   logic       rst, flush, valid_in, ready_out;
   logic [7:0] data_in;
   logic       rdy [4];
   logic       vout [4];
   logic [7:0] dout [4];
   logic [15:0] dcnt [4];
   int         cnt [4];
   int         vectors = 0, miscompares = 0;
   int         epoch = 0, seen_epoch = 0;
   logic [7:0] q [4][$];
   int         drops [4] = '{0, 0, 0, 0};

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int D = (g < 2) ? 4 : 3;
      localparam bit O = (g % 2) == 1;
      logic [$clog2(D+1)-1:0] c;
      skid_fifo #(.DATA_WIDTH(8), .DEPTH(D), .OVERWRITE_MODE(O), .DROP_CNT_WIDTH(16)) u_dut (
         .clk(clk), .rst(rst), .flush(flush), .data_in(data_in), .valid_in(valid_in),
         .ready_in(rdy[g]), .data_out(dout[g]), .valid_out(vout[g]), .ready_out(ready_out),
         .count(c), .drop_count(dcnt[g]));
      assign cnt[g] = int'(c);
   end

   task automatic chk(input string nm, input int inst, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s[u%0d] @%0t: got 0x%0h expected 0x%0h", nm, inst, $time, act, exp);
      end
   endtask

   // model update from pre-edge handshake, then compare post-edge outputs
   always @(posedge clk) begin : mon
      logic vi, ro, fl;
      logic [7:0] di;
      int d;
      bit o, ins, rem;
      vi = valid_in; ro = ready_out; fl = flush; di = data_in;
      if (epoch != seen_epoch || rst) begin
         seen_epoch = epoch;
         for (int i = 0; i < 4; i++) begin q[i].delete(); drops[i] = 0; end
      end
      if (!rst)
         for (int i = 0; i < 4; i++) begin
            d = (i < 2) ? 4 : 3;
            o = (i % 2) == 1;
            ins = vi && (q[i].size() < d || o);
            rem = ro && q[i].size() != 0;
            if (rem) void'(q[i].pop_front());
            if (fl) q[i].delete();
            else if (ins) begin
               if (o && !rem && q[i].size() == d) begin
                  void'(q[i].pop_front());
                  drops[i]++;
               end
               q[i].push_back(di);
            end
         end
      #1;
      for (int i = 0; i < 4; i++) begin
         d = (i < 2) ? 4 : 3;
         o = (i % 2) == 1;
         chk("count", i, cnt[i], q[i].size());
         chk("valid_out", i, int'(vout[i]), int'(q[i].size() != 0));
         chk("ready_in", i, int'(rdy[i]), int'(q[i].size() < d || o));
         chk("drop_count", i, int'(dcnt[i]), drops[i]);
         if (q[i].size() != 0) chk("data_out", i, int'(dout[i]), int'(q[i][0]));
      end
   end

   task automatic step(input logic v, input logic [7:0] d, input logic r, input logic f);
      valid_in = v; data_in = d; ready_out = r; flush = f;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; valid_in = 1'b0; data_in = '0; ready_out = 1'b0; flush = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ready", 0, int'(rdy[0]), 1);
      chk("rst_data", 0, int'(dout[0]), 0);
      rst = 1'b0;
      // empty pass-through
      step(1'b1, 8'hA5, 1'b1, 1'b0);
      chk("t1_valid", 0, int'(vout[0]), 1);
      chk("t1_data", 0, int'(dout[0]), 'hA5);
      chk("t1_count", 0, cnt[0], 1);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("t1_valid2", 0, int'(vout[0]), 0);
      chk("t1_count2", 0, cnt[0], 0);
      // fill then drain with source holding 05
      for (int k = 1; k <= 4; k++) step(1'b1, 8'(k), 1'b0, 1'b0);
      chk("t2_count", 0, cnt[0], 4);
      chk("t2_ready", 0, int'(rdy[0]), 0);
      step(1'b1, 8'h05, 1'b0, 1'b0);
      chk("t2_hold_ready", 0, int'(rdy[0]), 0);
      chk("t2_hold_data", 0, int'(dout[0]), 1);
      step(1'b1, 8'h05, 1'b1, 1'b0);
      chk("t2_ready_back", 0, int'(rdy[0]), 1);
      chk("t2_count3", 0, cnt[0], 3);
      chk("t2_data2", 0, int'(dout[0]), 2);
      step(1'b1, 8'h05, 1'b1, 1'b0);
      chk("t2_data3", 0, int'(dout[0]), 3);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("t2_data4", 0, int'(dout[0]), 4);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("t2_data5", 0, int'(dout[0]), 5);
      repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("t2_empty", 0, int'(vout[0]), 0);
      // full-rate streaming
      for (int i = 0; i < 100; i++) begin
         step(1'b1, 8'(i), 1'b1, 1'b0);
         chk("t3_count", 0, cnt[0], 1);
         chk("t3_data", 0, int'(dout[0]), i);
      end
      step(1'b0, 8'h00, 1'b1, 1'b0);
      // overwrite: u1 already dropped one item during the fill test
      for (int k = 1; k <= 6; k++) step(1'b1, 8'(k), 1'b0, 1'b0);
      chk("t4_count", 1, cnt[1], 4);
      chk("t4_drops", 1, int'(dcnt[1]), 3);
      chk("t4_ready", 1, int'(rdy[1]), 1);
      chk("t4_head", 1, int'(dout[1]), 3);
      for (int k = 4; k <= 6; k++) begin
         step(1'b0, 8'h00, 1'b1, 1'b0);
         chk("t4_drain", 1, int'(dout[1]), k);
      end
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("t4_empty", 1, int'(vout[1]), 0);
      // flush with a same-cycle insert
      for (int k = 1; k <= 3; k++) step(1'b1, 8'(8'h10 + k), 1'b0, 1'b0);
      chk("t5_count", 0, cnt[0], 3);
      step(1'b1, 8'h77, 1'b0, 1'b1);
      chk("t5_count0", 0, cnt[0], 0);
      chk("t5_valid", 0, int'(vout[0]), 0);
      chk("t5_ready", 0, int'(rdy[0]), 1);
      chk("t5_drops_kept", 1, int'(dcnt[1]), 3);
      repeat (2) step(1'b0, 8'h00, 1'b1, 1'b0);
      // asynchronous reset between edges
      step(1'b1, 8'h21, 1'b0, 1'b0);
      step(1'b1, 8'h22, 1'b0, 1'b0);
      valid_in = 1'b0;
      chk("t6_count2", 0, cnt[0], 2);
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_count", 0, cnt[0], 0);
      chk("t6_rst_valid", 0, int'(vout[0]), 0);
      chk("t6_rst_ready", 0, int'(rdy[0]), 1);
      chk("t6_rst_data", 0, int'(dout[0]), 0);
      chk("t6_rst_drops", 1, int'(dcnt[1]), 0);
      epoch++;
      #1 rst = 1'b0;
      step(1'b1, 8'h33, 1'b1, 1'b0);
      chk("t6_first", 0, int'(dout[0]), 'h33);
      chk("t6_first_cnt", 0, cnt[0], 1);
      // random traffic with alternating backpressure phases
      for (int n = 0; n < 10000; n++)
         step(1'($urandom_range(0, 99) < 60), 8'($urandom),
              1'($urandom_range(0, 99) < (((n / 500) % 2) == 1 ? 80 : 30)),
              1'($urandom_range(0, 63) == 0));
      repeat (6) step(1'b0, 8'h00, 1'b1, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
